// File: rtl/memory_access_stage.sv
// Memory stage of the 16-bit pipelined CPU: runs data-memory loads and stores
// over a req/ack handshake, stalls upstream while an access is outstanding,
// and flags accesses whose ack does not arrive within TIMEOUT cycles.
module memory_access_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wbs_in,
    input  logic              ni_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] writeData_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              out_valid,
    output logic              wbs_out,
    output logic              ni_out,
    output logic [DATA_W-1:0] memData_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic              mem_fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                live_q;
    // Fields captured at accept; they drive the memory port during ACCESS.
    logic                cap_we_q, cap_we_d;
    logic                cap_rd_q, cap_rd_d;
    logic                cap_wbs_q, cap_wbs_d;
    logic                cap_ni_q, cap_ni_d;
    logic [DATA_W-1:0]   cap_alu_q, cap_alu_d;
    logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
    // Output registers toward MemoryWriteback_register; they hold between pulses.
    logic                out_valid_q, out_valid_d;
    logic                wbs_q, wbs_d;
    logic                ni_q, ni_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic                fault_q, fault_d;

    logic                accept;

    // live_q keeps in_ready low until the first clock after reset release.
    assign in_ready = (state_q == S_IDLE) && live_q;
    assign accept   = in_valid && in_ready;

    // Memory port is decoded from state so an async reset drops dmem_req at once.
    assign dmem_req   = (state_q == S_ACCESS);
    assign dmem_we    = dmem_req && cap_we_q;
    assign dmem_addr  = dmem_req ? cap_alu_q[ADDR_W-1:0] : '0;
    assign dmem_wdata = dmem_req ? cap_wdata_q : '0;

    assign out_valid     = out_valid_q;
    assign wbs_out       = wbs_q;
    assign ni_out        = ni_q;
    assign memData_out   = mem_data_q;
    assign ALUresult_out = alu_q;
    assign mem_fault     = fault_q;

    // Next-state, capture and output-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_we_d    = cap_we_q;
        cap_rd_d    = cap_rd_q;
        cap_wbs_d   = cap_wbs_q;
        cap_ni_d    = cap_ni_q;
        cap_alu_d   = cap_alu_q;
        cap_wdata_d = cap_wdata_q;
        out_valid_d = 1'b0;
        wbs_d       = wbs_q;
        ni_d        = ni_q;
        mem_data_d  = mem_data_q;
        alu_d       = alu_q;
        fault_d     = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // A simultaneous read+write is a store; the read is dropped.
                    cap_we_d    = mem_write_in;
                    cap_rd_d    = mem_read_in && !mem_write_in;
                    cap_wbs_d   = wbs_in;
                    cap_ni_d    = ni_in;
                    cap_alu_d   = ALUresult_in;
                    cap_wdata_d = writeData_in;
                    if (mem_read_in || mem_write_in) begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        wbs_d       = wbs_in;
                        ni_d        = ni_in;
                        mem_data_d  = '0;
                        alu_d       = ALUresult_in;
                    end
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    // Ack takes priority over a timeout in the same cycle.
                    state_d     = S_RESP;
                    out_valid_d = 1'b1;
                    wbs_d       = cap_wbs_q;
                    ni_d        = cap_ni_q;
                    mem_data_d  = cap_rd_q ? dmem_rdata : '0;
                    alu_d       = cap_alu_q;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // TIMEOUT request cycles without ack: abandon, suppress writeback.
                    state_d     = S_RESP;
                    fault_d     = 1'b1;
                    out_valid_d = 1'b1;
                    wbs_d       = cap_wbs_q;
                    ni_d        = 1'b0;
                    mem_data_d  = '0;
                    alu_d       = cap_alu_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, capture and output registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            live_q      <= 1'b0;
            cap_we_q    <= 1'b0;
            cap_rd_q    <= 1'b0;
            cap_wbs_q   <= 1'b0;
            cap_ni_q    <= 1'b0;
            cap_alu_q   <= '0;
            cap_wdata_q <= '0;
            out_valid_q <= 1'b0;
            wbs_q       <= 1'b0;
            ni_q        <= 1'b0;
            mem_data_q  <= '0;
            alu_q       <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            live_q      <= 1'b1;
            cap_we_q    <= cap_we_d;
            cap_rd_q    <= cap_rd_d;
            cap_wbs_q   <= cap_wbs_d;
            cap_ni_q    <= cap_ni_d;
            cap_alu_q   <= cap_alu_d;
            cap_wdata_q <= cap_wdata_d;
            out_valid_q <= out_valid_d;
            wbs_q       <= wbs_d;
            ni_q        <= ni_d;
            mem_data_q  <= mem_data_d;
            alu_q       <= alu_d;
            fault_q     <= fault_d;
        end
    end

endmodule
